// File: rtl/led_pwm_fader.sv
// Four-channel LED PWM fader: duty ramps toward PATTERN ? MAX_DUTY : 0, one FADE_STEP per ramp tick.
// Latency: inputs registered 1 clk, LED pins 1 clk after duty/pwm_cnt; no backpressure (free-running).
module led_pwm_fader #(
  parameter int PWM_BITS       = 8,
  parameter int STEP_DIV       = 97656,
  parameter int FADE_STEP      = 1,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                FPGA_CLK,
  input  logic                RST,
  input  logic [3:0]          PATTERN,
  input  logic [PWM_BITS-1:0] MAX_DUTY,
  output logic [3:0]          LED,
  output logic                BUSY
);

  localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS+1)'(FADE_STEP);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_HOLD = 2'd2,
    ST_FALL = 2'd3
  } ch_state_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [3:0]          pattern_q;
  logic [PWM_BITS-1:0] maxd_q;
  logic [PWM_BITS-1:0] duty     [4];
  logic [PWM_BITS-1:0] duty_nxt [4];
  logic [PWM_BITS-1:0] target   [4];
  logic [PWM_BITS:0]   up_sum   [4];
  logic [PWM_BITS:0]   dn_sum   [4];
  ch_state_t           state     [4];
  ch_state_t           state_nxt [4];
  logic [3:0]          on;
  logic                busy_nxt;

  assign tick = (tick_cnt == TICK_W'(STEP_DIV - 1));

  // Ramp arithmetic is one bit wider so a step past either end clamps to the target instead of wrapping.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      target[i]   = pattern_q[i] ? maxd_q : '0;
      up_sum[i]   = {1'b0, duty[i]} + STEP_EXT;
      dn_sum[i]   = {1'b0, duty[i]} - STEP_EXT;
      duty_nxt[i] = duty[i];
      if (duty[i] < target[i]) begin
        duty_nxt[i] = (up_sum[i] > {1'b0, target[i]}) ? target[i] : up_sum[i][PWM_BITS-1:0];
      end else if (duty[i] > target[i]) begin
        duty_nxt[i] = (dn_sum[i][PWM_BITS] || (dn_sum[i][PWM_BITS-1:0] < target[i]))
                      ? target[i] : dn_sum[i][PWM_BITS-1:0];
      end
    end
  end

  always_comb begin
    busy_nxt = 1'b0;
    on       = '0;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      if (duty[i] < target[i]) begin
        state_nxt[i] = ST_RISE;
      end else if (duty[i] > target[i]) begin
        state_nxt[i] = ST_FALL;
      end else if (target[i] != '0) begin
        state_nxt[i] = ST_HOLD;
      end else begin
        state_nxt[i] = ST_OFF;
      end
      if (state[i] == ST_RISE || state[i] == ST_FALL) begin
        busy_nxt = 1'b1;
      end
      on[i] = (duty[i] > pwm_cnt);
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= ST_OFF;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
      end
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (RST) begin
      pwm_cnt   <= '0;
      tick_cnt  <= '0;
      pattern_q <= '0;
      maxd_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        duty[i] <= '0;
      end
      LED  <= {4{LED_ACTIVE_LOW}};
      BUSY <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      tick_cnt  <= tick ? '0 : tick_cnt + TICK_W'(1);
      pattern_q <= PATTERN;
      maxd_q    <= MAX_DUTY;
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          duty[i] <= duty_nxt[i];
        end
      end
      LED  <= on ^ {4{LED_ACTIVE_LOW}};
      BUSY <= busy_nxt;
    end
  end

endmodule
